// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles the ALU-side inputs, the data-memory request/ack
// port and the writeback packet of mem_stage. The slave modport is the
// view of mem_stage itself; master is the view of its surroundings
// (the ALU, the data memory and the writeback logic).
interface mem_stage_if #(
  parameter int REG_W = 4
);
  // ALU side
  logic             exe_mem;
  logic [63:0]      result;
  logic [63:0]      rflags;
  logic [1:0]       mem_op;
  logic [1:0]       mem_size;
  logic [63:0]      mem_addr_in;
  logic [REG_W-1:0] dst_reg;
  logic             mem_blocked;
  // data-memory port
  logic             mem_req;
  logic             mem_we;
  logic [63:0]      mem_addr;
  logic [63:0]      mem_wdata;
  logic [7:0]       mem_be;
  logic             mem_ack;
  logic [63:0]      mem_rdata;
  // writeback packet
  logic             wb_valid;
  logic [REG_W-1:0] wb_reg;
  logic [63:0]      wb_data;
  logic [63:0]      wb_rflags;
  logic             wb_err;

  modport slave (
    input  exe_mem, result, rflags, mem_op, mem_size, mem_addr_in, dst_reg,
    input  mem_ack, mem_rdata,
    output mem_blocked, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output wb_valid, wb_reg, wb_data, wb_rflags, wb_err
  );

  modport master (
    output exe_mem, result, rflags, mem_op, mem_size, mem_addr_in, dst_reg,
    output mem_ack, mem_rdata,
    input  mem_blocked, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  wb_valid, wb_reg, wb_data, wb_rflags, wb_err
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage behind the ALU. Captures one ALU result
// per exe_mem, performs an optional load/store over a req/ack port, and
// issues a registered one-cycle writeback packet. mem_blocked stalls the
// ALU while a memory request is outstanding.
// Optional feature macro: MEM_STAGE_TIMEOUT_EN -- abort a request that sees
// no mem_ack within TIMEOUT_CYCLES cycles and report it through wb_err.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int REG_W          = 4
) (
  input logic        clk,
  input logic        reset_n,
  mem_stage_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Byte mask of an access before lane shifting: 1/2/4/8 bytes.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  // Byte enables for the 8-byte lane; bytes shifted past lane 7 are lost.
  function automatic logic [7:0] lane_be(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] m;
    m = size_mask(size);
    lane_be = m << off;
  endfunction

  // Align load data to bit 0 and zero-extend to the access size.
  function automatic logic [63:0] load_extract(input logic [63:0] rdata,
                                               input logic [2:0]  off,
                                               input logic [1:0]  size);
    logic [63:0] sh;
    sh = rdata >> {off, 3'b000};
    case (size)
      2'b00:   load_extract = {56'd0, sh[7:0]};
      2'b01:   load_extract = {48'd0, sh[15:0]};
      2'b10:   load_extract = {32'd0, sh[31:0]};
      default: load_extract = sh;
    endcase
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  // Packet held across the REQ phase
  logic [REG_W-1:0] reg_q;
  logic [63:0]      res_q;
  logic [63:0]      flags_q;
  logic [2:0]       off_q;
  logic [1:0]       size_q;
  logic             store_q;

  // Registered outputs
  logic             mem_req_q;
  logic             mem_we_q;
  logic [63:0]      mem_addr_q;
  logic [63:0]      mem_wdata_q;
  logic [7:0]       mem_be_q;
  logic             wb_valid_q;
  logic [REG_W-1:0] wb_reg_q;
  logic [63:0]      wb_data_q;
  logic [63:0]      wb_rflags_q;
  logic             wb_err_q;

  logic             is_mem_d;
  logic             is_store_d;
  logic             timeout_d;

  // Opcode 11 decodes as neither load nor store.
  assign is_store_d = (bus.mem_op == 2'b10);
  assign is_mem_d   = (bus.mem_op == 2'b01) || is_store_d;

`ifdef MEM_STAGE_TIMEOUT_EN
  // Last waiting cycle reached: abort at this edge unless mem_ack arrives.
  assign timeout_d = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Requests wait for mem_ack indefinitely; the counter is never consulted.
  assign timeout_d = 1'b0;
`endif

  // Single-process FSM: capture, memory request, writeback, with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      reg_q       <= '0;
      res_q       <= '0;
      flags_q     <= '0;
      off_q       <= '0;
      size_q      <= '0;
      store_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
      wb_rflags_q <= '0;
      wb_err_q    <= 1'b0;
    end else begin
      case (state_q)
        REQ: begin
          // Memory outputs stay frozen until ack (or abort); no capture here.
          cnt_q <= cnt_q + 1'b1;
          if (bus.mem_ack) begin
            state_q     <= WB;
            mem_req_q   <= 1'b0;
            wb_valid_q  <= 1'b1;
            wb_err_q    <= 1'b0;
            wb_reg_q    <= store_q ? '0 : reg_q;
            wb_data_q   <= store_q ? res_q : load_extract(bus.mem_rdata, off_q, size_q);
            wb_rflags_q <= flags_q;
          end else if (timeout_d) begin
            state_q     <= WB;
            mem_req_q   <= 1'b0;
            wb_valid_q  <= 1'b1;
            wb_err_q    <= 1'b1;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
            wb_rflags_q <= flags_q;
          end
        end
        default: begin
          // IDLE or WB: the op the ALU is presenting may be taken now.
          wb_err_q <= 1'b0;
          if (bus.exe_mem) begin
            if (is_mem_d) begin
              state_q     <= REQ;
              cnt_q       <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store_d;
              mem_addr_q  <= {bus.mem_addr_in[63:3], 3'b000};
              mem_be_q    <= lane_be(bus.mem_size, bus.mem_addr_in[2:0]);
              mem_wdata_q <= bus.result << {bus.mem_addr_in[2:0], 3'b000};
              wb_valid_q  <= 1'b0;
              reg_q       <= bus.dst_reg;
              res_q       <= bus.result;
              flags_q     <= bus.rflags;
              off_q       <= bus.mem_addr_in[2:0];
              size_q      <= bus.mem_size;
              store_q     <= is_store_d;
            end else begin
              state_q     <= WB;
              wb_valid_q  <= 1'b1;
              wb_reg_q    <= bus.dst_reg;
              wb_data_q   <= bus.result;
              wb_rflags_q <= bus.rflags;
            end
          end else begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.mem_blocked = (state_q == REQ);
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_be      = mem_be_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_reg      = wb_reg_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_rflags   = wb_rflags_q;
  assign bus.wb_err      = wb_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage. Inputs change 1ns after a
// rising edge; outputs are checked at the same point, i.e. they reflect
// the edge just taken.
module tb_mem_stage;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  mem_stage_if #(.REG_W(4)) bus ();

  mem_stage #(
    .TIMEOUT_CYCLES(4),
    .REG_W(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic en, input logic [1:0] op, input logic [1:0] size,
                        input logic [63:0] addr, input logic [63:0] res,
                        input logic [3:0] dst, input logic [63:0] flags);
    bus.exe_mem     = en;
    bus.mem_op      = op;
    bus.mem_size    = size;
    bus.mem_addr_in = addr;
    bus.result      = res;
    bus.dst_reg     = dst;
    bus.rflags      = flags;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_op(1'b0, 2'b00, 2'b00, 64'h0, 64'h0, 4'h0, 64'h0);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 64'h0;
    tick();
    tick();

    // Reset state
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_blocked", bus.mem_blocked, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_wb_err", bus.wb_err, 0);
    reset_n = 1'b1;
    tick();

    // Pass-through: three back-to-back non-memory ops
    set_op(1'b1, 2'b00, 2'b00, 64'h0, 64'd1, 4'd1, 64'h10);
    tick();
    chk("pt1_valid", bus.wb_valid, 1);
    chk("pt1_data", bus.wb_data, 64'd1);
    chk("pt1_reg", bus.wb_reg, 4'd1);
    chk("pt1_flags", bus.wb_rflags, 64'h10);
    chk("pt1_blocked", bus.mem_blocked, 0);
    set_op(1'b1, 2'b00, 2'b00, 64'h0, 64'd2, 4'd2, 64'h11);
    tick();
    chk("pt2_valid", bus.wb_valid, 1);
    chk("pt2_data", bus.wb_data, 64'd2);
    chk("pt2_blocked", bus.mem_blocked, 0);
    set_op(1'b1, 2'b00, 2'b00, 64'h0, 64'd3, 4'd3, 64'h12);
    tick();
    chk("pt3_valid", bus.wb_valid, 1);
    chk("pt3_data", bus.wb_data, 64'd3);
    chk("pt3_blocked", bus.mem_blocked, 0);
    bus.exe_mem = 1'b0;
    tick();
    chk("pt_idle_valid", bus.wb_valid, 0);

    // Byte load at 0x1003, ack after two REQ cycles
    set_op(1'b1, 2'b01, 2'b00, 64'h1003, 64'h99, 4'd5, 64'h5);
    tick();
    bus.exe_mem = 1'b0;
    chk("ld_req", bus.mem_req, 1);
    chk("ld_addr", bus.mem_addr, 64'h1000);
    chk("ld_be", bus.mem_be, 8'h08);
    chk("ld_we", bus.mem_we, 0);
    chk("ld_blocked1", bus.mem_blocked, 1);
    chk("ld_wb_valid_req", bus.wb_valid, 0);
    tick();
    chk("ld_blocked2", bus.mem_blocked, 1);
    chk("ld_req2", bus.mem_req, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h1122334455667788;
    tick();
    bus.mem_ack = 1'b0;
    chk("ld_req_drop", bus.mem_req, 0);
    chk("ld_blocked_end", bus.mem_blocked, 0);
    chk("ld_wb_valid", bus.wb_valid, 1);
    chk("ld_wb_data", bus.wb_data, 64'h55);
    chk("ld_wb_reg", bus.wb_reg, 4'd5);
    tick();
    chk("ld_after_valid", bus.wb_valid, 0);

    // Dword store at 0x2004 with a pass-through op queued behind it
    set_op(1'b1, 2'b10, 2'b10, 64'h2004, 64'hDEADBEEF, 4'd7, 64'h20);
    tick();
    chk("st_we", bus.mem_we, 1);
    chk("st_be", bus.mem_be, 8'hF0);
    chk("st_wdata", bus.mem_wdata, 64'hDEADBEEF00000000);
    chk("st_addr", bus.mem_addr, 64'h2000);
    set_op(1'b1, 2'b00, 2'b00, 64'h0, 64'h77, 4'd3, 64'h30);
    tick();
    chk("st_hold_req", bus.mem_req, 1);
    chk("st_hold_wdata", bus.mem_wdata, 64'hDEADBEEF00000000);
    chk("st_no_capture", bus.wb_valid, 0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("st_wb_valid", bus.wb_valid, 1);
    chk("st_wb_reg", bus.wb_reg, 0);
    chk("st_wb_data", bus.wb_data, 64'hDEADBEEF);
    chk("st_wb_flags", bus.wb_rflags, 64'h20);
    chk("st_req_drop", bus.mem_req, 0);
    tick();
    bus.exe_mem = 1'b0;
    chk("q_wb_valid", bus.wb_valid, 1);
    chk("q_wb_data", bus.wb_data, 64'h77);
    chk("q_wb_reg", bus.wb_reg, 4'd3);
    tick();
    chk("q_once", bus.wb_valid, 0);

    // Stray ack while idle
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("stray_req", bus.mem_req, 0);
    chk("stray_valid", bus.wb_valid, 0);

    // Qword load at 0x3006: upper lanes only
    set_op(1'b1, 2'b01, 2'b11, 64'h3006, 64'h0, 4'd9, 64'h0);
    tick();
    bus.exe_mem = 1'b0;
    chk("qw_be", bus.mem_be, 8'hC0);
    chk("qw_addr", bus.mem_addr, 64'h3000);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'hAABB000000000000;
    tick();
    bus.mem_ack = 1'b0;
    chk("qw_wb_valid", bus.wb_valid, 1);
    chk("qw_wb_data", bus.wb_data, 64'hAABB);
    chk("qw_wb_reg", bus.wb_reg, 4'd9);
    tick();

    // mem_op 11 behaves as a non-memory op
    set_op(1'b1, 2'b11, 2'b00, 64'h4000, 64'h5A, 4'd4, 64'h0);
    tick();
    bus.exe_mem = 1'b0;
    chk("op11_req", bus.mem_req, 0);
    chk("op11_valid", bus.wb_valid, 1);
    chk("op11_data", bus.wb_data, 64'h5A);
    tick();

    // Unacknowledged load
    set_op(1'b1, 2'b01, 2'b10, 64'h10, 64'h0, 4'd6, 64'h0);
    tick();
    bus.exe_mem = 1'b0;
    tick();
    tick();
    tick();
    chk("to_req_3", bus.mem_req, 1);
    tick();
`ifdef MEM_STAGE_TIMEOUT_EN
    chk("to_req_drop", bus.mem_req, 0);
    chk("to_wb_valid", bus.wb_valid, 1);
    chk("to_wb_err", bus.wb_err, 1);
    chk("to_wb_data", bus.wb_data, 0);
    chk("to_wb_reg", bus.wb_reg, 0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("to_late_ack_valid", bus.wb_valid, 0);
    chk("to_late_ack_err", bus.wb_err, 0);
    chk("to_late_ack_req", bus.mem_req, 0);
`else
    tick();
    chk("noto_req", bus.mem_req, 1);
    chk("noto_blocked", bus.mem_blocked, 1);
    chk("noto_err", bus.wb_err, 0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h00000000CAFEF00D;
    tick();
    bus.mem_ack = 1'b0;
    chk("noto_wb_valid", bus.wb_valid, 1);
    chk("noto_wb_data", bus.wb_data, 64'hCAFEF00D);
    chk("noto_wb_err", bus.wb_err, 0);
    tick();
`endif

    // Asynchronous reset in the middle of a request
    set_op(1'b1, 2'b01, 2'b00, 64'h5001, 64'h0, 4'd8, 64'h0);
    tick();
    bus.exe_mem = 1'b0;
    chk("ar_req_before", bus.mem_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_mem_req", bus.mem_req, 0);
    chk("ar_blocked", bus.mem_blocked, 0);
    chk("ar_wb_valid", bus.wb_valid, 0);
    chk("ar_wb_data", bus.wb_data, 0);
    chk("ar_wb_reg", bus.wb_reg, 0);
    chk("ar_wb_rflags", bus.wb_rflags, 0);
    chk("ar_wb_err", bus.wb_err, 0);
    chk("ar_mem_be", bus.mem_be, 0);
    tick();
    reset_n = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.mem_ack = 1'b0;
    chk("ar_stray_valid", bus.wb_valid, 0);
    chk("ar_stray_req", bus.mem_req, 0);
    chk("ar_stray_data", bus.wb_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the ALU.
- Captures each ALU result qualified by exe_mem and performs the load or store through a simple request/acknowledge data-memory port.
- Presents a registered writeback packet to the register-file/flags update logic.
- Drives mem_blocked back to the ALU so the ALU holds its output registers while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: REQ cycles without mem_ack before abort. Used only with MEM_STAGE_TIMEOUT_EN.
- REG_W, 4: width of the destination register index.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- exe_mem  in  1  ALU output valid.
- result  in  64  ALU result. Store data for stores; writeback data otherwise.
- rflags  in  64  ALU flags, passed through to writeback.
- mem_op  in  2  00 none, 01 load, 10 store, 11 treated as none.
- mem_size  in  2  00 byte, 01 word, 10 dword, 11 qword.
- mem_addr_in  in  64  effective address.
- dst_reg  in  REG_W  writeback destination.
- mem_blocked  out  1  to ALU: hold outputs.
- mem_req  out  1  data-memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  64  address aligned down to 8 bytes.
- mem_wdata  out  64  lane-shifted store data.
- mem_be  out  8  byte enables.
- mem_ack  in  1  request accepted/completed, sampled while mem_req=1.
- mem_rdata  in  64  read data, valid with mem_ack.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_reg  out  REG_W  destination.
- wb_data  out  64  writeback value.
- wb_rflags  out  64  flags.
- wb_err  out  1  access aborted.

Behaviour:
- Reset: clock is clk; reset_n is asynchronous, active-low. All registered outputs go to 0 immediately and state goes to IDLE. mem_req drops asynchronously even mid-access; a later stray mem_ack is ignored.
- States:
  - IDLE: no outstanding work.
  - REQ: mem_req held high.
  - WB: wb_valid=1 for this cycle.
- Capture: a packet is captured at a posedge when exe_mem=1 and state is IDLE or WB. No capture occurs in REQ.
- mem_blocked: combinational, equals (state==REQ).
  - The ALU keeps presenting the next op while blocked; that op is captured in the WB cycle.
  - No duplicate capture.
- Non-memory op: captured, then WB next cycle (latency 1). Back-to-back ops give WB→WB every cycle.
  - wb_data = result[63:0].
  - wb_rflags = rflags.
- Memory op: captured, then REQ. On entry, drive mem_req=1, mem_addr = {addr[63:3],3'b0}, mem_we = (mem_op==10), and mem_be = size mask (1/3/15/255 bytes) << addr[2:0], truncated to 8 bits.
- Stores: mem_wdata = result << (8*addr[2:0]).
- Bytes past lane 7 are dropped; no split access.
- REQ persists with all memory outputs stable until mem_ack=1 at a posedge. Then mem_req=0 and state goes to WB.
- Load WB: wb_data = (mem_rdata >> 8*addr[2:0]) masked to size, zero-extended. Lanes beyond 7 read as 0.
- Store WB: wb_valid=1, wb_reg = 0 (no register write), wb_data = result.
- WB exit: if no capture, go to IDLE and wb_valid returns to 0. Otherwise go to WB or REQ per the new op.
- mem_ack outside REQ is ignored.
- mem_op=11 behaves as none.

Optional Feature:
- Macro: MEM_STAGE_TIMEOUT_EN.
- With the macro: a counter clears on REQ entry. If it reaches TIMEOUT_CYCLES without mem_ack:
  - mem_req drops.
  - State goes to WB with wb_err=1, wb_data=0, wb_reg=0.
  - wb_err is otherwise 0.
- Without the macro: REQ waits indefinitely and wb_err is tied to 0.

Test Plan:
1. Reset: reset_n=0 mid-REQ → mem_req=0 and mem_blocked=0 without waiting for a clock; all wb_* = 0.
2. Pass-through: three consecutive exe_mem ops, result 1, 2, 3, mem_op=00 → wb_valid high three consecutive cycles, wb_data 1, 2, 3; mem_blocked stays 0.
3. Load: byte load, addr 0x1003; mem_ack after 2 REQ cycles with rdata 0x1122334455667788 → mem_addr 0x1000, mem_be 0x08, mem_blocked high 2 cycles, then wb_data 0x55.
4. Store:
   - dword store, addr 0x2004, result 0xDEADBEEF → mem_we=1, mem_be 0xF0, mem_wdata 0xDEADBEEF00000000, wb_reg=0.
   - Queued pass-through op behind it → captured in the store's WB cycle exactly once.
5. Boundary: qword load at addr 0x3006, rdata 0xAABB000000000000 → mem_be 0xC0, wb_data 0xAABB.
6. Timeout: with MEM_STAGE_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → mem_req low after 4 cycles, wb_valid=1, wb_err=1; a later mem_ack is ignored.
